// File: rtl/bank_scheduler.sv
// Double-buffered bank scheduler for the cell-automaton frame store.
// Four single-port RAMs form two banks. Each bank has an evolve copy and a display copy.
// While a generation evolves, the active bank k is read:
//   - its evolve copy by the round engine,
//   - its display copy by the VGA scanner.
// Both copies of the other bank receive the next generation.
// The banks swap only during vertical blanking, so the screen never tears.
// Init and SD-preset loaders write all four RAMs at once.
module bank_scheduler #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                  clk_vga,
  input  logic                  reset_btn,
  input  logic                  init_busy,
  input  logic                  init_wden,
  input  logic [ADDR_W-1:0]     init_addr,
  input  logic [DATA_W-1:0]     init_data,
  input  logic                  preset_busy,
  input  logic                  preset_wden,
  input  logic [ADDR_W-1:0]     preset_addr,
  input  logic [DATA_W-1:0]     preset_data,
  input  logic                  run_en,
  input  logic                  evo_tick,
  input  logic                  gen_done,
  input  logic                  vga_vblank,
  input  logic [ADDR_W-1:0]     round_rd_addr,
  input  logic [ADDR_W-1:0]     round_wr_addr,
  input  logic                  round_wden,
  input  logic [DATA_W-1:0]     round_wr_data,
  input  logic [ADDR_W-1:0]     vga_addr,
  input  logic [4*DATA_W-1:0]   ram_q,
  output logic [4*ADDR_W-1:0]   ram_addr,
  output logic [3:0]            ram_wren,
  output logic [3:0]            ram_rden,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W-1:0]     round_rd_data,
  output logic [DATA_W-1:0]     vga_data,
  output logic                  evo_go,
  output logic                  active_bank,
  output logic                  swap_pending,
  output logic [15:0]           gen_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_PRESET    = 3'd1,
    S_IDLE      = 3'd2,
    S_EVOLVE    = 3'd3,
    S_WAIT_SWAP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        active_bank_q, active_bank_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        evo_go_q, evo_go_d;
  // High when the previous cycle was a loader state. While high, the display
  // read is still in flight from a loader cycle and must be blanked.
  logic        load_prev_q, load_prev_d;

  // A loader taking over in this cycle discards any round write in flight.
  logic        round_wr_ok;
  assign round_wr_ok = round_wden & ~preset_busy & ~init_busy;

  // State register: reset lands in S_INIT with bank 0 and the display blanked.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q       <= S_INIT;
      active_bank_q <= 1'b0;
      gen_count_q   <= 16'h0000;
      evo_go_q      <= 1'b0;
      load_prev_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      gen_count_q   <= gen_count_d;
      evo_go_q      <= evo_go_d;
      load_prev_q   <= load_prev_d;
    end
  end

  // Next-state logic.
  // init_busy overrides everything. preset_busy aborts any run-time state.
  // Generations advance only on tick, done and vblank.
  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    gen_count_d   = gen_count_q;
    evo_go_d      = 1'b0;
    load_prev_d   = (state_q == S_INIT) || (state_q == S_PRESET);

    if (init_busy) begin
      state_d       = S_INIT;
      active_bank_d = 1'b0;
      gen_count_d   = 16'h0000;
    end else if (preset_busy &&
                 (state_q inside {S_IDLE, S_EVOLVE, S_WAIT_SWAP})) begin
      state_d       = S_PRESET;
      active_bank_d = 1'b0;
      gen_count_d   = 16'h0000;
    end else begin
      case (state_q)
        S_INIT: begin
          state_d = preset_busy ? S_PRESET : S_IDLE;
        end
        S_PRESET: begin
          if (!preset_busy) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (run_en && evo_tick) begin
            state_d  = S_EVOLVE;
            evo_go_d = 1'b1;
          end
        end
        S_EVOLVE: begin
          // Dropping run_en here does not abort the generation; only gen_done ends it.
          if (gen_done) state_d = S_WAIT_SWAP;
        end
        S_WAIT_SWAP: begin
          if (vga_vblank) begin
            state_d       = S_IDLE;
            active_bank_d = ~active_bank_q;
            gen_count_d   = gen_count_q + 16'h0001;
          end
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  // RAM port muxing.
  // RAM n belongs to bank n/2. Even RAMs are evolve copies; odd RAMs are display copies.
  // Unused lanes park at address 0 with both strobes low.
  always_comb begin
    ram_addr  = '0;
    ram_wren  = '0;
    ram_rden  = '0;
    ram_wdata = '0;
    if (!reset_btn) begin
      case (state_q)
        S_INIT: begin
          for (int n = 0; n < 4; n++) begin
            ram_addr[n*ADDR_W +: ADDR_W] = init_addr;
            ram_wren[n]                  = init_wden;
          end
          ram_wdata = init_data;
        end
        S_PRESET: begin
          for (int n = 0; n < 4; n++) begin
            ram_addr[n*ADDR_W +: ADDR_W] = preset_addr;
            ram_wren[n]                  = preset_wden;
          end
          ram_wdata = preset_data;
        end
        S_EVOLVE: begin
          for (int n = 0; n < 4; n++) begin
            if ((n >= 2) == active_bank_q) begin
              ram_addr[n*ADDR_W +: ADDR_W] = (n % 2 == 0) ? round_rd_addr : vga_addr;
              ram_rden[n]                  = 1'b1;
            end else begin
              ram_addr[n*ADDR_W +: ADDR_W] = round_wr_addr;
              ram_wren[n]                  = round_wr_ok;
            end
          end
          ram_wdata = round_wr_data;
        end
        S_IDLE, S_WAIT_SWAP: begin
          for (int n = 0; n < 4; n++) begin
            if (((n >= 2) == active_bank_q) && (n % 2 == 1)) begin
              ram_addr[n*ADDR_W +: ADDR_W] = vga_addr;
              ram_rden[n]                  = 1'b1;
            end
          end
        end
        default: begin
          ram_wren = '0;
        end
      endcase
    end
  end

  // Read data muxing.
  // Select the active bank's evolve copy for the round engine and its display copy for VGA.
  assign round_rd_data = active_bank_q ? ram_q[2*DATA_W +: DATA_W] : ram_q[0 +: DATA_W];
  assign vga_data      = load_prev_q ? '0 :
                         (active_bank_q ? ram_q[3*DATA_W +: DATA_W] : ram_q[1*DATA_W +: DATA_W]);

  assign evo_go       = evo_go_q;
  assign active_bank  = active_bank_q;
  assign gen_count    = gen_count_q;
  assign swap_pending = (state_q == S_WAIT_SWAP);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bank_scheduler.sv
// Bench for bank_scheduler.
// - Four 16-word RAM models sit behind the DUT.
// - A mode-level reference model predicts every RAM strobe, the status outputs and the read data.
// - Display reads flow through an expected queue.
module tb_bank_scheduler;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int M_INIT = 0, M_PRESET = 1, M_IDLE = 2, M_EVOLVE = 3, M_WAIT = 4;

  logic clk_vga = 1'b0;
  logic reset_btn;
  logic init_busy, init_wden, preset_busy, preset_wden;
  logic [AW-1:0] init_addr, preset_addr, round_rd_addr, round_wr_addr, vga_addr;
  logic [DW-1:0] init_data, preset_data, round_wr_data;
  logic run_en, evo_tick, gen_done, vga_vblank, round_wden;
  logic [4*DW-1:0] ram_q;
  logic [4*AW-1:0] ram_addr;
  logic [3:0] ram_wren, ram_rden;
  logic [DW-1:0] ram_wdata, round_rd_data, vga_data;
  logic evo_go, active_bank, swap_pending;
  logic [15:0] gen_count;
  logic [2:0] dbg_state;

  bank_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_vga(clk_vga), .reset_btn(reset_btn),
    .init_busy(init_busy), .init_wden(init_wden), .init_addr(init_addr), .init_data(init_data),
    .preset_busy(preset_busy), .preset_wden(preset_wden), .preset_addr(preset_addr),
    .preset_data(preset_data), .run_en(run_en), .evo_tick(evo_tick), .gen_done(gen_done),
    .vga_vblank(vga_vblank), .round_rd_addr(round_rd_addr), .round_wr_addr(round_wr_addr),
    .round_wden(round_wden), .round_wr_data(round_wr_data), .vga_addr(vga_addr),
    .ram_q(ram_q), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_wdata(ram_wdata), .round_rd_data(round_rd_data), .vga_data(vga_data),
    .evo_go(evo_go), .active_bank(active_bank), .swap_pending(swap_pending),
    .gen_count(gen_count), .dbg_state(dbg_state)
  );

  // Clock and RAM models
  always #5 clk_vga = ~clk_vga;

  logic [DW-1:0] ram_mem [4][16];
  logic [DW-1:0] ram_rd [4];
  always @(posedge clk_vga) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_wren[n]) ram_mem[n][ram_addr[n*AW +: 4]] <= ram_wdata;
      if (ram_rden[n]) ram_rd[n] <= ram_mem[n][ram_addr[n*AW +: 4]];
    end
  end
  assign ram_q = {ram_rd[3], ram_rd[2], ram_rd[1], ram_rd[0]};

  // Reference model state
  int            m_mode;
  logic          m_bank;
  logic [15:0]   m_cnt;
  logic          m_go;
  logic          m_blank;
  logic [DW-1:0] exp_mem [4][16];
  logic [DW-1:0] exp_q[$];
  logic          exp_bank_q[$];
  logic          rd_ok, rd_bank;
  logic [DW-1:0] rd_exp;
  logic [3:0]    e_wren, e_rden;
  logic [AW-1:0] e_addr [4];
  logic [DW-1:0] e_wdata;

  int n_checks = 0;
  int n_errs = 0;

  // Scoreboard
  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_INIT; m_bank = 1'b0; m_cnt = 16'h0; m_go = 1'b0; m_blank = 1'b1;
    rd_ok = 1'b0;
    exp_q.delete(); exp_bank_q.delete();
  endtask

  // Expected RAM strobes for the current model mode and current inputs.
  task automatic model_ports();
    int ev, dp;
    ev = 2 * int'(m_bank);
    dp = ev + 1;
    e_wren = '0; e_rden = '0; e_wdata = '0;
    for (int n = 0; n < 4; n++) e_addr[n] = '0;
    if (reset_btn) return;
    case (m_mode)
      M_INIT: begin
        for (int n = 0; n < 4; n++) e_addr[n] = init_addr;
        e_wren = init_wden ? 4'hF : 4'h0;
        e_wdata = init_data;
      end
      M_PRESET: begin
        for (int n = 0; n < 4; n++) e_addr[n] = preset_addr;
        e_wren = preset_wden ? 4'hF : 4'h0;
        e_wdata = preset_data;
      end
      M_EVOLVE: begin
        e_rden[ev] = 1'b1; e_addr[ev] = round_rd_addr;
        e_rden[dp] = 1'b1; e_addr[dp] = vga_addr;
        for (int n = 0; n < 4; n++) begin
          if (n != ev && n != dp) begin
            e_addr[n] = round_wr_addr;
            e_wren[n] = round_wden && !preset_busy && !init_busy;
          end
        end
        e_wdata = round_wr_data;
      end
      M_IDLE, M_WAIT: begin
        e_rden[dp] = 1'b1; e_addr[dp] = vga_addr;
      end
      default: ;
    endcase
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_step();
    int old_mode, ev;
    if (reset_btn) begin model_reset(); return; end
    model_ports();
    old_mode = m_mode;
    ev = 2 * int'(m_bank);
    if (e_rden[ev + 1]) begin
      exp_q.push_back(exp_mem[ev + 1][vga_addr[3:0]]);
      exp_bank_q.push_back(m_bank);
    end
    rd_ok = e_rden[ev];
    rd_bank = m_bank;
    rd_exp = exp_mem[ev][round_rd_addr[3:0]];
    for (int n = 0; n < 4; n++) if (e_wren[n]) exp_mem[n][e_addr[n][3:0]] = e_wdata;
    m_go = 1'b0;
    m_blank = (old_mode == M_INIT) || (old_mode == M_PRESET);
    if (init_busy) begin
      m_mode = M_INIT; m_bank = 1'b0; m_cnt = 16'h0;
    end else if (preset_busy && (old_mode inside {M_IDLE, M_EVOLVE, M_WAIT})) begin
      m_mode = M_PRESET; m_bank = 1'b0; m_cnt = 16'h0;
    end else begin
      case (old_mode)
        M_INIT:   m_mode = preset_busy ? M_PRESET : M_IDLE;
        M_PRESET: if (!preset_busy) m_mode = M_IDLE;
        M_IDLE:   if (run_en && evo_tick) begin m_mode = M_EVOLVE; m_go = 1'b1; end
        M_EVOLVE: if (gen_done) m_mode = M_WAIT;
        M_WAIT:   if (vga_vblank) begin m_mode = M_IDLE; m_bank = ~m_bank; m_cnt = m_cnt + 16'h1; end
        default:  m_mode = M_INIT;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] v_exp;
    logic v_bank;
    logic have_v;
    if (reset_btn) model_reset();
    model_ports();
    check_eq("ram_wren", ram_wren, e_wren);
    check_eq("ram_rden", ram_rden, e_rden);
    for (int n = 0; n < 4; n++)
      if (e_wren[n] || e_rden[n])
        check_eq($sformatf("ram_addr%0d", n), ram_addr[n*AW +: AW], e_addr[n]);
    if (e_wren != 4'h0) check_eq("ram_wdata", ram_wdata, e_wdata);
    check_eq("evo_go", evo_go, m_go);
    check_eq("active_bank", active_bank, m_bank);
    check_eq("gen_count", gen_count, m_cnt);
    check_eq("swap_pending", swap_pending, m_mode == M_WAIT);
    have_v = exp_q.size() > 0;
    v_exp = '0; v_bank = 1'b0;
    if (have_v) begin v_exp = exp_q.pop_front(); v_bank = exp_bank_q.pop_front(); end
    if (m_blank) check_eq("vga_data_blank", vga_data, 32'h0);
    else if (have_v && v_bank == m_bank) check_eq("vga_data", vga_data, v_exp);
    if (!reset_btn && rd_ok && rd_bank == m_bank) check_eq("round_rd_data", round_rd_data, rd_exp);
  endtask

  // Driver tasks: one call = one clock; inputs are set by the caller at the falling edge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk_vga);
    model_step();
    @(negedge clk_vga);
  endtask

  task automatic rand_round();
    round_rd_addr = AW'($urandom_range(0, 15));
    round_wr_addr = AW'($urandom_range(0, 15));
    round_wr_data = DW'($urandom);
    round_wden    = 1'($urandom_range(0, 1));
    vga_addr      = AW'($urandom_range(0, 15));
  endtask

  // One full generation from S_IDLE; stray pulses in the wrong states must be ignored.
  task automatic run_gen(input int ev_len, input int wt_len);
    rand_round(); run_en = 1'b1; evo_tick = 1'b1; gen_done = 1'($urandom_range(0, 1));
    vga_vblank = 1'($urandom_range(0, 1));
    cycle();
    evo_tick = 1'b0; gen_done = 1'b0;
    for (int i = 0; i < ev_len; i++) begin
      rand_round(); run_en = 1'($urandom_range(0, 1)); evo_tick = 1'($urandom_range(0, 1));
      vga_vblank = 1'($urandom_range(0, 1)); cycle();
    end
    rand_round(); gen_done = 1'b1; evo_tick = 1'b0; vga_vblank = 1'b0; cycle();
    gen_done = 1'b0;
    for (int i = 0; i < wt_len; i++) begin
      rand_round(); vga_vblank = 1'b0; evo_tick = 1'($urandom_range(0, 1));
      gen_done = 1'($urandom_range(0, 1)); cycle();
    end
    rand_round(); vga_vblank = 1'b1; evo_tick = 1'b0; gen_done = 1'b0; cycle();
    vga_vblank = 1'b0; run_en = 1'b0;
  endtask

  task automatic enter_evolve(input int len);
    rand_round(); run_en = 1'b1; evo_tick = 1'b1; cycle();
    evo_tick = 1'b0;
    for (int i = 0; i < len; i++) begin rand_round(); cycle(); end
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 16; a++) begin ram_mem[n][a] = '0; exp_mem[n][a] = '0; end
    for (int n = 0; n < 4; n++) ram_rd[n] = '0;
    reset_btn = 1'b0; init_busy = 1'b0; init_wden = 1'b0; init_addr = '0; init_data = '0;
    preset_busy = 1'b0; preset_wden = 1'b0; preset_addr = '0; preset_data = '0;
    run_en = 1'b0; evo_tick = 1'b0; gen_done = 1'b0; vga_vblank = 1'b0;
    round_rd_addr = '0; round_wr_addr = '0; round_wden = 1'b0; round_wr_data = '0; vga_addr = '0;
    model_reset();
    #2 reset_btn = 1'b1;
    @(negedge clk_vga);
    repeat (3) cycle();
    reset_btn = 1'b0;

    // Init fill of all four RAMs, then S_IDLE with the display blanked one cycle.
    for (int i = 0; i < 16; i++) begin
      rand_round(); init_busy = 1'b1; init_wden = 1'b1; init_addr = AW'(i); init_data = 32'hA5A5A5A5;
      run_en = 1'($urandom_range(0, 1)); evo_tick = 1'($urandom_range(0, 1));
      gen_done = 1'($urandom_range(0, 1)); cycle();
    end
    init_busy = 1'b0; init_wden = 1'b0; run_en = 1'b0; evo_tick = 1'b0; gen_done = 1'b0;
    cycle();
    repeat (4) begin rand_round(); cycle(); end

    // Generations, including a long wait for vblank.
    run_gen(5, 100);
    check_eq("bank_after_swap1", active_bank, 1'b1);
    check_eq("count_after_swap1", gen_count, 16'h1);
    for (int g = 0; g < 6; g++) run_gen($urandom_range(1, 20), $urandom_range(0, 10));
    repeat (3) begin rand_round(); cycle(); end

    // Counter wrap: preload 0xFFFF while idle, then one more swap.
    run_en = 1'b0; evo_tick = 1'b0;
    force dut.gen_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cycle();
    release dut.gen_count_q;
    run_gen(3, 2);
    check_eq("gen_count_wrap", gen_count, 16'h0000);

    // Preset during a generation aborts it.
    enter_evolve(4);
    rand_round(); round_wden = 1'b1; preset_busy = 1'b1; preset_wden = 1'b1;
    preset_addr = AW'($urandom_range(0, 15)); preset_data = DW'($urandom); cycle();
    check_eq("preset_bank", active_bank, 1'b0);
    check_eq("preset_count", gen_count, 16'h0);
    for (int i = 0; i < 6; i++) begin
      rand_round(); round_wden = 1'b1; preset_wden = 1'($urandom_range(0, 1));
      preset_addr = AW'($urandom_range(0, 15)); preset_data = DW'($urandom); cycle();
    end
    preset_busy = 1'b0; preset_wden = 1'b0;
    repeat (4) begin rand_round(); cycle(); end

    // init_busy and gen_done together: init wins, no swap.
    run_gen(2, 1);
    enter_evolve(3);
    rand_round(); init_busy = 1'b1; init_wden = 1'b0; gen_done = 1'b1; cycle();
    gen_done = 1'b0;
    check_eq("init_no_swap", swap_pending, 1'b0);
    check_eq("init_count", gen_count, 16'h0);
    init_busy = 1'b0; cycle();
    repeat (3) begin rand_round(); cycle(); end

    // Asynchronous reset while a swap is pending.
    enter_evolve(2);
    rand_round(); gen_done = 1'b1; cycle(); gen_done = 1'b0;
    rand_round(); cycle();
    reset_btn = 1'b1;
    #1 check_eq("reset_async_swap", swap_pending, 1'b0);
    check_eq("reset_async_wren", ram_wren, 4'h0);
    cycle();
    reset_btn = 1'b0; cycle();
    repeat (3) begin rand_round(); cycle(); end

    // Random soak with all control inputs free-running.
    for (int i = 0; i < 2000; i++) begin
      rand_round();
      init_busy = ($urandom_range(0, 63) == 0); init_wden = 1'($urandom_range(0, 1));
      init_addr = AW'($urandom_range(0, 15)); init_data = DW'($urandom);
      preset_busy = ($urandom_range(0, 31) == 0); preset_wden = 1'($urandom_range(0, 1));
      preset_addr = AW'($urandom_range(0, 15)); preset_data = DW'($urandom);
      run_en = ($urandom_range(0, 3) != 0); evo_tick = ($urandom_range(0, 3) == 0);
      gen_done = ($urandom_range(0, 7) == 0); vga_vblank = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
